// File: rtl/shift_sequencer.sv
// Iterative 32-bit shifter that applies one power-of-two stage per clock, walking shamt LSB first.
// Optional macro SHIFT_SEQ_EARLY_EXIT_EN finishes once no higher shamt bits remain.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] data_out,
    output logic             result_rdy,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t           state_q, state_d;
    logic [SHW-1:0]   stage_q, stage_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [1:0]       op_q, op_d;
    logic             cur_bit;
    logic             last_stage;

    // One stage of the shifter: move by 2**k positions according to op.
    function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] a,
                                                     input logic [SHW-1:0]   k,
                                                     input logic [1:0]       o);
        int unsigned            n;
        logic signed [WIDTH-1:0] s;
        n = 32'd1 << k;
        s = a;
        case (o)
            OP_SLL:  shift_stage = a << n;
            OP_SRL:  shift_stage = a >> n;
            OP_SRA:  shift_stage = s >>> n;
            default: shift_stage = (a >> n) | (a << (WIDTH - n));
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        dout_d     = dout_q;
        acc_d      = acc_q;
        shamt_d    = shamt_q;
        op_d       = op_q;
        cur_bit    = |(shamt_q & (SHW'(1) << stage_q));
        last_stage = (stage_q == SHW'(SHW - 1));
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        // Nothing left to do once every shamt bit above this stage is clear.
        last_stage = last_stage || ((shamt_q >> stage_q) <= SHW'(1));
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = data_in;
                    shamt_d = shamt;
                    op_d    = op;
                    stage_d = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cur_bit) begin
                    acc_d = shift_stage(acc_q, stage_q, op_q);
                end
                stage_d = stage_q + SHW'(1);
                if (last_stage) begin
                    state_d = DONE;
                    dout_d  = acc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            dout_q  <= dout_d;
        end
    end

    // Operand registers only matter while SHIFT is active, so they carry no reset.
    always_ff @(posedge clock) begin
        acc_q   <= acc_d;
        shamt_q <= shamt_d;
        op_q    <= op_d;
    end

    assign data_out   = dout_q;
    assign result_rdy = (state_q == DONE);
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized scoreboard bench for shift_sequencer; latency expectations follow SHIFT_SEQ_EARLY_EXIT_EN.
module tb_shift_sequencer;
    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_out;
    logic             result_rdy;
    logic             busy;

    shift_sequencer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in),
        .shamt(shamt), .op(op), .data_out(data_out), .result_rdy(result_rdy), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] val;
        int          start_cyc;
        int          exp_cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          last_start = 0;
    int          last_exp = 0;
    logic [31:0] exp_out = 32'h0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: whole shift in one step from plain arithmetic.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic [1:0] o);
        logic [63:0] w;
        case (o)
            2'b00: w = {32'h0, d << s};
            2'b01: w = {32'h0, d >> s};
            2'b10: w = {{32{d[31]}}, d} >> s;
            default: w = {d, d} >> s;
        endcase
        return w[31:0];
    endfunction

    function automatic int exp_lat(input logic [4:0] s);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        for (int h = 4; h >= 0; h--) if (s[h]) return h + 1;
        return 1;
`else
        return SHW;
`endif
    endfunction

    // Monitor: busy window, result pulse timing and held data_out.
    always @(negedge clock) begin : monitor
        logic eb;
        exp_t e;
        eb = (sb.size() > 0) && (cyc >= sb[0].start_cyc) && (cyc < sb[0].exp_cyc);
        check("busy", {31'h0, busy}, {31'h0, eb});
        if (result_rdy) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rdy: actual 1 required 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("rdy_cycle", 32'(cyc), 32'(e.exp_cyc));
                exp_out = e.val;
            end
        end else if (sb.size() > 0 && cyc >= sb[0].exp_cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_rdy: actual 0 required 1 (cycle %0d)", cyc);
            void'(sb.pop_front());
        end
        check("data_out", data_out, exp_out);
    end

    task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                         input logic [31:0] ev);
        exp_t e;
        start   = 1'b1;
        data_in = d;
        shamt   = s;
        op      = o;
        e.val       = ev;
        e.start_cyc = cyc + 1;
        e.exp_cyc   = cyc + 1 + exp_lat(s);
        sb.push_back(e);
        last_start = e.start_cyc;
        last_exp   = e.exp_cyc;
        @(negedge clock);
        start   = 1'b0;
        data_in = $urandom;
        shamt   = 5'($urandom);
        op      = 2'($urandom);
    endtask

    // Idle until cycle target; optionally throw ignored start pulses while busy.
    task automatic wait_until(input int target, input bit noise);
        while (cyc < target) begin
            if (noise && cyc >= last_start && cyc < last_exp) begin
                start   = 1'($urandom_range(0, 1));
                data_in = $urandom;
                shamt   = 5'($urandom);
                op      = 2'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    task automatic run(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                       input logic [31:0] ev);
        issue(d, s, o, ev);
        wait_until(last_exp + 1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  o;
        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        shamt   = '0;
        op      = '0;
        repeat (3) @(negedge clock);
        check("rst_rdy", {31'h0, result_rdy}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        run(32'h2AAAAAAA, 5'd1, 2'b10, 32'h15555555);
        run(32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF);
        run(32'h80000000, 5'd31, 2'b01, 32'h00000001);
        run(32'h00000001, 5'd31, 2'b00, 32'h80000000);
        run(32'h00000001, 5'd4, 2'b11, 32'h10000000);
        for (int k = 0; k < 4; k++) run(32'hDEADBEEF, 5'd0, 2'(k), 32'hDEADBEEF);
        run(32'h00000010, 5'd3, 2'b01, 32'h00000002);
        run(32'h00000001, 5'd16, 2'b00, 32'h00010000);

        // Start while busy is ignored; then a start in the DONE cycle is accepted.
        issue(32'h0000FFFF, 5'd8, 2'b00, 32'h00FFFF00);
        start = 1'b1; data_in = 32'h12345678; shamt = 5'd3; op = 2'b11;
        @(negedge clock);
        start = 1'b0;
        wait_until(last_exp, 1'b0);
        issue(32'hF0000000, 5'd4, 2'b10, 32'hFF000000);
        wait_until(last_exp + 1, 1'b0);

        // Reset in the middle of SHIFT aborts without a result.
        issue(32'hCAFEF00D, 5'd16, 2'b11, 32'hF00DCAFE);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        sb.delete();
        exp_out = 32'h0;
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        run(32'h0000000F, 5'd2, 2'b00, 32'h0000003C);

        for (int i = 0; i < 300; i++) begin
            d = $urandom;
            s = 5'($urandom);
            o = 2'($urandom);
            if (i % 8 == 0) s = 5'($urandom_range(0, 1)) ? 5'd31 : 5'd0;
            issue(d, s, o, ref_shift(d, s, o));
            wait_until(last_exp + $urandom_range(0, 3), 1'b1);
        end

        wait_until(last_exp + 3, 1'b0);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift controller for the ALU's 32-bit shift path.
- Replaces the single-cycle combinational barrel shift with an iterative engine: one power-of-two stage per clock, stepping through the shift-amount bits LSB first.
- Sits beside the ALU and is driven by the execute stage with a start/result-ready handshake, the same style as the multiply/divide unit.
- Supports logical left, logical right, arithmetic right and rotate right.

Parameters:
- WIDTH, 32, operand/result width. Must equal 2**SHW.
- SHW, 5, shift-amount width; also the number of shift stages.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; samples operand, amount and op.
- data_in  input  WIDTH  operand.
- shamt  input  SHW  shift amount, 0..WIDTH-1.
- op  input  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = ROR.
- data_out  output  WIDTH  result; held stable until the next accepted start.
- result_rdy  output  1  one-cycle pulse; data_out is valid.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (synchronous, sampled at the clock edge):
  - state = IDLE; data_out = 0; result_rdy = 0; busy = 0; stage counter = 0.
  - Reset dominates start on the same edge.
  - Reset during SHIFT aborts the operation; no result_rdy is produced.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE with start = 1:
  - Latch data_in into the accumulator, and latch shamt and op.
  - stage = 0; go to SHIFT.
  - Back-to-back start in DONE is legal.
- IDLE or DONE with start = 0: DONE returns to IDLE after exactly one cycle; IDLE stays in IDLE.
- SHIFT, each edge:
  - If latched shamt[stage] = 1, shift the accumulator by 2**stage per op.
  - SLL and SRL zero-fill. SRA fills with the accumulator MSB. ROR wraps the bits shifted out of the LSB into the MSB.
  - stage increments. After stage SHW-1 is processed, go to DONE.
- start is ignored while busy (SHIFT). The latched operands are unaffected.
- On entry to DONE:
  - data_out <= final accumulator.
  - result_rdy = 1 for exactly the DONE cycle.
- busy = 1 exactly when state = SHIFT.
- Latency: result_rdy is high in the cycle following the SHW-th edge after the start-sampling edge, i.e. 5 cycles for the defaults, independent of shamt.
- Boundary conditions:
  - shamt = 0 still takes the full latency; data_out = data_in.
  - shamt = 31 with SRA on a negative operand gives 0xFFFFFFFF.
  - data_out keeps its old value during SHIFT.
- Changes to data_in, shamt or op after the start edge have no effect on the operation in flight.

Optional Feature:
- Macro: SHIFT_SEQ_EARLY_EXIT_EN.
- Defined: after processing stage k, if latched shamt[SHW-1:k+1] == 0, go directly to DONE.
  - Latency = h+1 cycles, where h is the index of the highest set bit of shamt.
  - shamt = 0 gives latency 1 (stage 0 processed as a no-op).
  - The result is identical to the non-early-exit result.
- Undefined: fixed SHW-cycle latency as described in Behaviour.

Test Plan:
- SRA: data_in = 0x2AAAAAAA, shamt = 1, op = 10 → result_rdy pulses 5 cycles after start (feature off); data_out = 0x15555555; busy high for exactly 5 cycles.
- SRA / SRL / SLL extremes:
  - data_in = 0x80000000, shamt = 31, op = 10 → data_out = 0xFFFFFFFF.
  - Same with op = 01 → 0x00000001.
  - data_in = 0x00000001, shamt = 31, op = 00 → 0x80000000.
- ROR and zero shift:
  - data_in = 0x00000001, shamt = 4, op = 11 → data_out = 0x10000000.
  - shamt = 0, any op → data_out = data_in after full latency.
- Start while busy: start with 0x0000FFFF, shamt = 8, op = 00; re-pulse start 2 cycles later with different operands → single result_rdy; data_out = 0x00FFFF00. Then start in the DONE cycle → accepted; second result correct.
- Reset mid-operation: assert reset 3 cycles into SHIFT → next cycle busy = 0, data_out = 0, no result_rdy; a fresh start afterwards completes normally.
- Early exit (SHIFT_SEQ_EARLY_EXIT_EN defined):
  - shamt = 0 → result_rdy 1 cycle after start.
  - shamt = 3 → 2 cycles.
  - shamt = 16 → 5 cycles.
  - Results match the feature-off runs.
